alu_regfile_psr: RTL and testbench
==================================

// Module: alu_regfile_psr
// PURPOSE
//  Register file and processor status register (PSR) directly upstream/downstream of the ALU.
//  Two read ports drive the ALU A/B inputs. The write port captures the ALU Output (writeback).
//  The PSR latches ALU Flags under a per-bit mask and returns PSR carry to ALU cin.
//  Write-to-read bypass lets back-to-back dependent ALU ops see fresh data in the same cycle.
// PARAMETERS
//  DATA_W   16  register / ALU operand width
//  NREGS    16  number of general registers
//  ADDR_W    4  register address width, clog2(NREGS)
//  FLAG_W    5  PSR width: [0]C carry, [1]L unsigned-low, [2]F overflow, [3]Z equal, [4]N signed-low
// PORTS
//  clk          in   1       rising-edge clock
//  reset_n      in   1       asynchronous active-low reset
//  rd_addr_a    in   ADDR_W  read port A address (Rdest)
//  rd_addr_b    in   ADDR_W  read port B address (Rsrc)
//  rd_data_a    out  DATA_W  operand to ALU A
//  rd_data_b    out  DATA_W  operand to ALU B
//  wr_en        in   1       writeback enable
//  wr_addr      in   ADDR_W  writeback address
//  wr_data      in   DATA_W  writeback data (ALU Output)
//  flags_in     in   FLAG_W  ALU Flags
//  flags_we     in   FLAG_W  per-bit PSR update mask (e.g. CMP=5'b11110, ADD=5'b00101)
//  psr_wr_en    in   1       direct PSR load (restore after interrupt / LPR)
//  psr_wr_data  in   FLAG_W  data for direct PSR load
//  psr          out  FLAG_W  registered PSR
//  alu_cin      out  1       equals psr[0]; drives ALU cin
// BEHAVIOUR
//  - Reset (reset_n low, async): all NREGS registers = 0, psr = 0, alu_cin = 0.
//    The bypass path is gated off while reset_n is low, so rd_data_a/b read 0.
//  - Reads are combinational: rd_data_x = regs[rd_addr_x], zero-latency.
//  - Bypass: if wr_en && wr_addr == rd_addr_x && reset_n, then rd_data_x = wr_data (same cycle).
//    Ports A and B bypass independently; both may bypass at once.
//  - Write: on posedge clk with wr_en, regs[wr_addr] <= wr_data. One-cycle latency to the array.
//    The bypass hides that latency from readers.
//  - PSR update on posedge clk, in priority order:
//      psr_wr_en = 1 -> psr <= psr_wr_data; flags_we is ignored that cycle.
//      else, for each bit i -> psr[i] <= flags_we[i] ? flags_in[i] : psr[i].
//  - Simultaneous wr_en and PSR update are independent; both take effect in the same edge.
//  - wr_en and psr_wr_en are not interlocked; all input combinations are legal.
//  - Reset asserted mid-cycle clears state immediately (async).
//    The first write is accepted on the first posedge after reset_n rises.
//  - Address width exactly covers NREGS; no out-of-range handling is required.
//  - No X propagation: the array and PSR are fully reset.
// STRUCTURE
//  - Shared package alu_pkg holds:
//      localparams DATA_W, ADDR_W, FLAG_W;
//      flag indices FLG_C=0, FLG_L=1, FLG_F=2, FLG_Z=3, FLG_N=4;
//      ALU op codes OP_AND=8'h01, OP_OR=8'h02, OP_XOR=8'h03, OP_ADD=8'h05, OP_CMP=8'h0B,
//      OP_LSH=8'h84, OP_ASHU=8'h86;
//      per-op flag masks FLAGMASK_CMP=5'b11110, FLAGMASK_ADD=5'b00101, FLAGMASK_LOGIC=5'b00000.
//  - One sub-module psr_reg: the masked PSR register with the psr_wr_en priority rule.
//  - The register array and bypass muxes are inline in alu_regfile_psr.
// TESTING
//  1 Reset: load R3=16'h1234, PSR=5'b10101, pulse reset_n low mid-cycle
//    -> rd_data_a(R3)=0, psr=0, alu_cin=0 immediately.
//  2 Write/read: wr R5=16'hFFFF, next cycle read A=R5, B=R0 -> rd_data_a=16'hFFFF, rd_data_b=0.
//  3 Bypass: same cycle wr_en, wr_addr=7, wr_data=16'h00C8, rd_addr_a=rd_addr_b=7
//    -> both read 16'h00C8 before the edge; after the edge, regs[7]=16'h00C8.
//  4 Masked flags: psr=0, flags_in=5'b11111, flags_we=FLAGMASK_ADD
//    -> psr=5'b00101, alu_cin=1; then flags_in=0, flags_we=0 -> psr holds 5'b00101.
//  5 CMP update: psr=5'b00001, flags_in=5'b01000 (A=B=3), flags_we=FLAGMASK_CMP
//    -> psr=5'b01001 (carry preserved).
//  6 Priority: psr_wr_en=1, psr_wr_data=5'b10000, flags_we=5'b11111, flags_in=5'b01111
//    -> psr=5'b10000.
//  Bench plus ALU loop: R1=65535, R2=100, ADD writeback R1 -> R1=16'h0063, psr[0]=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, PSR flag indices, opcodes and the
// per-op PSR update masks.
package alu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREGS  = 16;
  localparam int unsigned ADDR_W = $clog2(NREGS);
  localparam int unsigned FLAG_W = 5;

  localparam int unsigned FLG_C = 0;
  localparam int unsigned FLG_L = 1;
  localparam int unsigned FLG_F = 2;
  localparam int unsigned FLG_Z = 3;
  localparam int unsigned FLG_N = 4;

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_LSH  = 8'h84;
  localparam logic [7:0] OP_ASHU = 8'h86;

  localparam logic [FLAG_W-1:0] FLAGMASK_CMP   = 5'b11110;
  localparam logic [FLAG_W-1:0] FLAGMASK_ADD   = 5'b00101;
  localparam logic [FLAG_W-1:0] FLAGMASK_LOGIC = 5'b00000;

endpackage

// File: rtl/alu_regfile_psr_psr_reg.sv
// Processor status register: a direct load wins over the per-bit masked
// update from the ALU flags.
module psr_reg
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [FLAG_W-1:0] flags_we,
  input  logic              psr_wr_en,
  input  logic [FLAG_W-1:0] psr_wr_data,
  output logic [FLAG_W-1:0] psr
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psr <= '0;
    end else if (psr_wr_en) begin
      psr <= psr_wr_data;
    end else begin
      psr <= (flags_we & flags_in) | (~flags_we & psr);
    end
  end

endmodule

// File: rtl/alu_regfile_psr.sv
// Register file and PSR around the ALU: two combinational read ports with
// write-to-read bypass, one writeback port, and the PSR feeding ALU carry-in.
module alu_regfile_psr
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [FLAG_W-1:0] flags_we,
  input  logic              psr_wr_en,
  input  logic [FLAG_W-1:0] psr_wr_data,
  output logic [FLAG_W-1:0] psr,
  output logic              alu_cin
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Bypass hides the one-cycle write latency from a dependent read.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
    if (reset_n && wr_en && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
    end
    if (reset_n && wr_en && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
    end
  end

  psr_reg u_psr_reg (
    .clk         (clk),
    .reset_n     (reset_n),
    .flags_in    (flags_in),
    .flags_we    (flags_we),
    .psr_wr_en   (psr_wr_en),
    .psr_wr_data (psr_wr_data),
    .psr         (psr)
  );

  assign alu_cin = psr[FLG_C];

endmodule

// File: tb/tb_alu_regfile_psr.sv
// Directed bench for alu_regfile_psr, ending with a small ALU writeback loop.
module tb_alu_regfile_psr;
  import alu_pkg::*;

  logic              clk;
  logic              reset_n;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [FLAG_W-1:0] flags_in;
  logic [FLAG_W-1:0] flags_we;
  logic              psr_wr_en;
  logic [FLAG_W-1:0] psr_wr_data;
  logic [FLAG_W-1:0] psr;
  logic              alu_cin;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] alu_res;
  logic [FLAG_W-1:0] alu_flg;

  alu_regfile_psr dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .rd_data_a   (rd_data_a),
    .rd_data_b   (rd_data_b),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .flags_in    (flags_in),
    .flags_we    (flags_we),
    .psr_wr_en   (psr_wr_en),
    .psr_wr_data (psr_wr_data),
    .psr         (psr),
    .alu_cin     (alu_cin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en     = 1'b0;
    flags_we  = '0;
    flags_in  = '0;
    psr_wr_en = 1'b0;
  endtask

  // Reference ALU producing the writeback value and flags.
  task automatic alu_model(input logic [7:0] op, input logic [DATA_W-1:0] a,
                           input logic [DATA_W-1:0] b, input logic cin,
                           output logic [DATA_W-1:0] r, output logic [FLAG_W-1:0] f);
    logic [DATA_W:0] s;
    r = '0;
    f = '0;
    s = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b} + 17'(cin);
        r = s[DATA_W-1:0];
        f[FLG_C] = s[DATA_W];
        f[FLG_F] = (a[15] == b[15]) && (r[15] != a[15]);
      end
      OP_CMP: begin
        f[FLG_Z] = (a == b);
        f[FLG_L] = (a < b);
        f[FLG_N] = ($signed(a) < $signed(b));
      end
      OP_LSH:  r = a << b[3:0];
      OP_ASHU: r = 16'($signed(a) >>> b[3:0]);
      default: r = a;
    endcase
  endtask

  initial begin
    reset_n = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    wr_addr = '0;
    wr_data = '0;
    psr_wr_data = '0;
    idle();
    #12;
    check("por_rd_a", 32'(rd_data_a), 32'h0);
    check("por_psr", 32'(psr), 32'h0);
    reset_n = 1'b1;
    step();

    // Reset: load R3 and PSR, then async reset mid-cycle.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
    psr_wr_en = 1'b1; psr_wr_data = 5'b10101;
    step();
    idle();
    rd_addr_a = 4'd3;
    #1;
    check("pre_rst_r3", 32'(rd_data_a), 32'h1234);
    check("pre_rst_psr", 32'(psr), 32'h15);
    check("pre_rst_cin", 32'(alu_cin), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    check("rst_r3", 32'(rd_data_a), 32'h0);
    check("rst_psr", 32'(psr), 32'h0);
    check("rst_cin", 32'(alu_cin), 32'h0);
    // Bypass must be gated off while in reset.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
    #1;
    check("rst_no_bypass", 32'(rd_data_a), 32'h0);
    wr_en = 1'b0;
    #1 reset_n = 1'b1;
    step();

    // Write/read: first write after reset, read back next cycle.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hFFFF;
    step();
    idle();
    rd_addr_a = 4'd5; rd_addr_b = 4'd0;
    #1;
    check("rd_a_r5", 32'(rd_data_a), 32'hFFFF);
    check("rd_b_r0", 32'(rd_data_b), 32'h0);

    // Bypass on both ports, then from the array.
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h00C8;
    rd_addr_a = 4'd7; rd_addr_b = 4'd7;
    #1;
    check("byp_a", 32'(rd_data_a), 32'h00C8);
    check("byp_b", 32'(rd_data_b), 32'h00C8);
    step();
    idle();
    #1;
    check("arr_r7", 32'(rd_data_a), 32'h00C8);
    // Independent bypass: only port A matches.
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h0055;
    rd_addr_a = 4'd9; rd_addr_b = 4'd7;
    #1;
    check("byp_a_only", 32'(rd_data_a), 32'h0055);
    check("nobyp_b", 32'(rd_data_b), 32'h00C8);
    step();
    idle();

    // Masked flags with the ADD mask, then hold.
    flags_in = 5'b11111; flags_we = FLAGMASK_ADD;
    step();
    idle();
    check("add_mask_psr", 32'(psr), 32'h05);
    check("add_mask_cin", 32'(alu_cin), 32'h1);
    step();
    check("hold_psr", 32'(psr), 32'h05);

    // CMP update preserves carry.
    psr_wr_en = 1'b1; psr_wr_data = 5'b00001;
    step();
    idle();
    flags_in = 5'b01000; flags_we = FLAGMASK_CMP;
    step();
    idle();
    check("cmp_psr", 32'(psr), 32'h09);

    // Direct load beats the masked update.
    psr_wr_en = 1'b1; psr_wr_data = 5'b10000;
    flags_we = 5'b11111; flags_in = 5'b01111;
    step();
    idle();
    check("prio_psr", 32'(psr), 32'h10);
    check("prio_cin", 32'(alu_cin), 32'h0);

    // ALU loop: R1=65535, R2=100, ADD R2 into R1.
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'hFFFF;
    step();
    wr_addr = 4'd2; wr_data = 16'd100;
    step();
    idle();
    rd_addr_a = 4'd1; rd_addr_b = 4'd2;
    #1;
    alu_model(OP_ADD, rd_data_a, rd_data_b, alu_cin, alu_res, alu_flg);
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = alu_res;
    flags_in = alu_flg; flags_we = FLAGMASK_ADD;
    #1;
    check("add_byp_r1", 32'(rd_data_a), 32'h0063);
    step();
    idle();
    check("add_r1", 32'(rd_data_a), 32'h0063);
    check("add_psr", 32'(psr), 32'h11);
    check("add_cin", 32'(alu_cin), 32'h1);

    // CMP R1(0x63) vs R2(0x64): low in both senses, not equal.
    alu_model(OP_CMP, rd_data_a, rd_data_b, alu_cin, alu_res, alu_flg);
    flags_in = alu_flg; flags_we = FLAGMASK_CMP;
    step();
    idle();
    check("cmp2_psr", 32'(psr), 32'h13);

    // AND into R2 leaves the PSR untouched.
    alu_model(OP_AND, rd_data_a, rd_data_b, alu_cin, alu_res, alu_flg);
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = alu_res;
    flags_in = 5'b11111; flags_we = FLAGMASK_LOGIC;
    step();
    idle();
    check("and_r2", 32'(rd_data_b), 32'h0060);
    check("and_psr", 32'(psr), 32'h13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
